control_sequencer: RTL and testbench

Hardwired control unit for the single-bus CPU datapath. It steps through fetch (T0–T2) and execute (T3–T6) for the register-ALU, immediate-ALU, mul/div, neg/not, nop and halt instructions. On every clock it drives the datapath's bus-drive, register-load, memory and ALU-select strobes directly, decoding from the instruction register. It replaces the hand-scripted strobe sequences used in datapath benches.

---
 rtl/control_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired fetch/execute strobe sequencer for the single-bus
//                CPU datapath. Moore decode of the T-state plus the IR.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR,
   output logic        PC_out,
   output logic        MDR_out,
   output logic        Zlo_out,
   output logic        Zhi_out,
   output logic        C_out,
   output logic        MAR_rd,
   output logic        MDR_rd,
   output logic        IR_rd,
   output logic        Y_rd,
   output logic        Z_rd,
   output logic        HI_rd,
   output logic        LO_rd,
   output logic        IncPC,
   output logic        Read,
   output logic [15:0] R_wrt,
   output logic [15:0] R_rd,
   output logic [4:0]  op_sel,
   output logic        run,
   output logic        illegal,
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   state_t r_state;
   state_t w_next_state;
   logic   r_illegal;

   // Instruction fields
   logic [4:0] w_opcode;
   logic [3:0] w_ra;
   logic [3:0] w_rb;
   logic [3:0] w_rc;
   assign w_opcode = IR[31:27];
   assign w_ra     = IR[26:23];
   assign w_rb     = IR[22:19];
   assign w_rc     = IR[18:15];

   // Instruction classes
   logic       w_is_alu3;
   logic       w_is_imm;
   logic       w_is_md;
   logic       w_is_nn;
   logic       w_is_nop;
   logic       w_executes;
   logic [4:0] w_imm_op;

   assign w_is_alu3  = (w_opcode >= 5'b00011) && (w_opcode <= 5'b01011);
   assign w_is_imm   = (w_opcode >= 5'b01100) && (w_opcode <= 5'b01110);
   assign w_is_md    = (w_opcode == 5'b01111) || (w_opcode == 5'b10000);
   assign w_is_nn    = (w_opcode == 5'b10001) || (w_opcode == 5'b10010);
   assign w_is_nop   = (w_opcode == 5'b11010);
   assign w_executes = w_is_alu3 | w_is_imm | w_is_md | w_is_nn;

   // Immediate forms reuse the register-form ALU codes (add/and/or)
   always_comb begin
      w_imm_op = 5'b00000;
      case (w_opcode)
         5'b01100: w_imm_op = 5'b00011;
         5'b01101: w_imm_op = 5'b00101;
         5'b01110: w_imm_op = 5'b00110;
         default:  w_imm_op = 5'b00000;
      endcase
   end

   // State register; clr abandons any partial instruction
   always_ff @(posedge clk or posedge clr) begin
      if (clr) r_state <= S_RST;
      else     r_state <= w_next_state;
   end

   // Sticky flag for an unsupported opcode seen at decode; only clr clears it
   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         r_illegal <= 1'b0;
      else if (r_state == S_T2 && !w_executes && !w_is_nop && w_opcode != 5'b11011)
         r_illegal <= 1'b1;
   end

   // Next-state and strobe decode from the current state and IR
   always_comb begin
      w_next_state = r_state;
      PC_out  = 1'b0;
      MDR_out = 1'b0;
      Zlo_out = 1'b0;
      Zhi_out = 1'b0;
      C_out   = 1'b0;
      MAR_rd  = 1'b0;
      MDR_rd  = 1'b0;
      IR_rd   = 1'b0;
      Y_rd    = 1'b0;
      Z_rd    = 1'b0;
      HI_rd   = 1'b0;
      LO_rd   = 1'b0;
      IncPC   = 1'b0;
      Read    = 1'b0;
      R_wrt   = 16'h0000;
      R_rd    = 16'h0000;
      op_sel  = 5'b00000;
      case (r_state)
         S_RST: w_next_state = S_T0;
         S_T0: begin
            PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1;
            w_next_state = S_T1;
         end
         S_T1: begin
            Read = 1'b1; MDR_rd = 1'b1;
            w_next_state = S_T2;
         end
         S_T2: begin
            MDR_out = 1'b1; IR_rd = 1'b1;
            if (w_executes)    w_next_state = S_T3;
            else if (w_is_nop) w_next_state = S_T0;
            else               w_next_state = S_HALT;
         end
         S_T3: begin
            w_next_state = w_executes ? S_T4 : S_T0;
            if (w_is_alu3 || w_is_imm) begin
               R_wrt = 16'h0001 << w_rb; Y_rd = 1'b1;
            end else if (w_is_md) begin
               R_wrt = 16'h0001 << w_ra; Y_rd = 1'b1;
            end else if (w_is_nn) begin
               R_wrt = 16'h0001 << w_rb; op_sel = w_opcode; Z_rd = 1'b1;
            end
         end
         S_T4: begin
            w_next_state = (w_is_alu3 || w_is_imm || w_is_md) ? S_T5 : S_T0;
            if (w_is_alu3) begin
               R_wrt = 16'h0001 << w_rc; op_sel = w_opcode; Z_rd = 1'b1;
            end else if (w_is_imm) begin
               C_out = 1'b1; op_sel = w_imm_op; Z_rd = 1'b1;
            end else if (w_is_md) begin
               R_wrt = 16'h0001 << w_rb; op_sel = w_opcode; Z_rd = 1'b1;
            end else if (w_is_nn) begin
               Zlo_out = 1'b1; R_rd = 16'h0001 << w_ra;
            end
         end
         S_T5: begin
            w_next_state = w_is_md ? S_T6 : S_T0;
            if (w_is_alu3 || w_is_imm) begin
               Zlo_out = 1'b1; R_rd = 16'h0001 << w_ra;
            end else if (w_is_md) begin
               Zlo_out = 1'b1; LO_rd = 1'b1;
            end
         end
         S_T6: begin
            w_next_state = S_T0;
            if (w_is_md) begin
               Zhi_out = 1'b1; HI_rd = 1'b1;
            end
         end
         S_HALT: w_next_state = S_HALT;
         default: w_next_state = S_RST;
      endcase
   end

   // run drops asynchronously with clr and stays low once halted
   assign run       = !clr && (r_state != S_HALT);
   assign illegal   = r_illegal;
   assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Table-driven per-cycle check of the control_sequencer strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] IR  = 32'h0;
   logic PC_out, MDR_out, Zlo_out, Zhi_out, C_out;
   logic MAR_rd, MDR_rd, IR_rd, Y_rd, Z_rd, HI_rd, LO_rd, IncPC, Read;
   logic [15:0] R_wrt, R_rd;
   logic [4:0]  op_sel;
   logic        run, illegal;
   logic [3:0]  state_dbg;

   control_sequencer dut (
      .clk(clk), .clr(clr), .IR(IR),
      .PC_out(PC_out), .MDR_out(MDR_out), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out), .C_out(C_out),
      .MAR_rd(MAR_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd), .Z_rd(Z_rd),
      .HI_rd(HI_rd), .LO_rd(LO_rd), .IncPC(IncPC), .Read(Read),
      .R_wrt(R_wrt), .R_rd(R_rd), .op_sel(op_sel), .run(run), .illegal(illegal),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Strobe bit positions in the packed 14-bit strobe field
   localparam logic [13:0] PCO  = 14'h2000;
   localparam logic [13:0] MDRO = 14'h1000;
   localparam logic [13:0] ZLO  = 14'h0800;
   localparam logic [13:0] ZHI  = 14'h0400;
   localparam logic [13:0] CO   = 14'h0200;
   localparam logic [13:0] MARR = 14'h0100;
   localparam logic [13:0] MDRR = 14'h0080;
   localparam logic [13:0] IRR  = 14'h0040;
   localparam logic [13:0] YR   = 14'h0020;
   localparam logic [13:0] ZR   = 14'h0010;
   localparam logic [13:0] HIR  = 14'h0008;
   localparam logic [13:0] LOR  = 14'h0004;
   localparam logic [13:0] INC  = 14'h0002;
   localparam logic [13:0] RD   = 14'h0001;

   typedef struct packed {
      logic [31:0] ir;
      logic [13:0] stb;
      logic [15:0] wrt;
      logic [15:0] rd;
      logic [4:0]  op;
      logic        run;
      logic        ill;
      logic [3:0]  st;
   } vec_t;

   vec_t vecs[$];
   int   passed = 0;
   int   total  = 0;

   function automatic vec_t mk(input logic [31:0] ir, input logic [13:0] stb,
                               input logic [15:0] wrt, input logic [15:0] rd,
                               input logic [4:0] op, input logic rn, input logic il,
                               input logic [3:0] st);
      vec_t v;
      v.ir = ir; v.stb = stb; v.wrt = wrt; v.rd = rd;
      v.op = op; v.run = rn; v.ill = il; v.st = st;
      return v;
   endfunction

   // Three fetch cycles common to every instruction
   task automatic add_fetch(input logic [31:0] ir);
      vecs.push_back(mk(ir, PCO | MARR | INC, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 4'd1));
      vecs.push_back(mk(ir, RD | MDRR,        16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 4'd2));
      vecs.push_back(mk(ir, MDRO | IRR,       16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 4'd3));
   endtask

   task automatic check(input string name, input vec_t exp);
      vec_t act;
      act = {exp.ir, PC_out, MDR_out, Zlo_out, Zhi_out, C_out, MAR_rd, MDR_rd, IR_rd,
             Y_rd, Z_rd, HI_rd, LO_rd, IncPC, Read, R_wrt, R_rd, op_sel, run, illegal,
             state_dbg};
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got stb=%h wrt=%h rd=%h op=%b run=%b ill=%b st=%0d, expected stb=%h wrt=%h rd=%h op=%b run=%b ill=%b st=%0d",
                    name, act.stb, act.wrt, act.rd, act.op, act.run, act.ill, act.st,
                    exp.stb, exp.wrt, exp.rd, exp.op, exp.run, exp.ill, exp.st);
   endtask

   initial begin
      // RST after clr release
      vecs.push_back(mk(32'h0, 14'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 4'd0));
      // and R4,R5,R7
      add_fetch(32'h2A2B8000);
      vecs.push_back(mk(32'h2A2B8000, YR,  16'h0020, 16'h0, 5'b00000, 1'b1, 1'b0, 4'd4));
      vecs.push_back(mk(32'h2A2B8000, ZR,  16'h0080, 16'h0, 5'b00101, 1'b1, 1'b0, 4'd5));
      vecs.push_back(mk(32'h2A2B8000, ZLO, 16'h0, 16'h0010, 5'b00000, 1'b1, 1'b0, 4'd6));
      // neg R5,R0
      add_fetch(32'h8A800000);
      vecs.push_back(mk(32'h8A800000, ZR,  16'h0001, 16'h0, 5'b10001, 1'b1, 1'b0, 4'd4));
      vecs.push_back(mk(32'h8A800000, ZLO, 16'h0, 16'h0020, 5'b00000, 1'b1, 1'b0, 4'd5));
      // addi R2,R1,-5
      add_fetch(32'h610FFFFB);
      vecs.push_back(mk(32'h610FFFFB, YR,      16'h0002, 16'h0, 5'b00000, 1'b1, 1'b0, 4'd4));
      vecs.push_back(mk(32'h610FFFFB, CO | ZR, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0, 4'd5));
      vecs.push_back(mk(32'h610FFFFB, ZLO,     16'h0, 16'h0004, 5'b00000, 1'b1, 1'b0, 4'd6));
      // ori R0,R0,#0
      add_fetch(32'h70000000);
      vecs.push_back(mk(32'h70000000, YR,      16'h0001, 16'h0, 5'b00000, 1'b1, 1'b0, 4'd4));
      vecs.push_back(mk(32'h70000000, CO | ZR, 16'h0, 16'h0, 5'b00110, 1'b1, 1'b0, 4'd5));
      vecs.push_back(mk(32'h70000000, ZLO,     16'h0, 16'h0001, 5'b00000, 1'b1, 1'b0, 4'd6));
      // mul R3,R4
      add_fetch(32'h81A00000);
      vecs.push_back(mk(32'h81A00000, YR,        16'h0008, 16'h0, 5'b00000, 1'b1, 1'b0, 4'd4));
      vecs.push_back(mk(32'h81A00000, ZR,        16'h0010, 16'h0, 5'b10000, 1'b1, 1'b0, 4'd5));
      vecs.push_back(mk(32'h81A00000, ZLO | LOR, 16'h0, 16'h0, 5'b00000, 1'b1, 1'b0, 4'd6));
      vecs.push_back(mk(32'h81A00000, ZHI | HIR, 16'h0, 16'h0, 5'b00000, 1'b1, 1'b0, 4'd7));
      // nop: back to T0 straight after T2
      add_fetch(32'hD0000000);
      // halt, then ten idle cycles in HALT
      add_fetch(32'hD8000000);
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(32'hD8000000, 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 4'd8));

      repeat (2) @(posedge clk);
      #2 clr = 1'b0;
      foreach (vecs[i]) begin
         @(negedge clk);
         IR = vecs[i].ir;
         #1 check($sformatf("vec%0d", i), vecs[i]);
      end

      // clr mid-T4 of an add R1,R2,R3 (opcode 00011)
      clr = 1'b1;
      @(posedge clk);
      #2 clr = 1'b0;
      IR = 32'h18918000;
      repeat (5) @(posedge clk);  // RST->T0->T1->T2->T3->T4
      #1 check("add_T4", mk(IR, ZR, 16'h0008, 16'h0, 5'b00011, 1'b1, 1'b0, 4'd5));
      #2 clr = 1'b1;
      #1 check("clr_async", mk(IR, 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 4'd0));
      @(posedge clk);
      #2 clr = 1'b0;
      #1 check("rst_release", mk(IR, 14'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 4'd0));
      @(posedge clk);
      #1 check("restart_T0", mk(IR, PCO | MARR | INC, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0, 4'd1));

      // Illegal opcode 11111 goes to HALT with sticky illegal
      IR = 32'hF8000000;
      repeat (3) @(posedge clk);  // T1, T2, HALT
      #1 check("illegal_halt", mk(IR, 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 4'd8));
      repeat (3) @(posedge clk);
      #1 check("illegal_sticky", mk(IR, 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 4'd8));
      #2 clr = 1'b1;
      #1 check("illegal_clr", mk(IR, 14'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 4'd0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
